ndp_result_packer: RTL and testbench

- Downstream stage of the NDP core's result stream. It accepts 32-bit AXI4-Stream beats, each holding two WIDTH=16 result lanes.
- Applies optional ReLU per lane, packs beat pairs into 64-bit words and buffers them in a small FIFO for the 64-bit write-back DMA.
- Checks each result frame against the expected beat count.
- Reports errors and completed frames as status outputs.

---
 rtl/ndp_result_packer.sv | 206 ++++++++++++++++++++
 tb/tb_ndp_result_packer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ndp_result_packer.sv
// ndp_result_packer: takes two-lane 32-bit result beats, applies optional
// per-lane ReLU, packs beat pairs into 64-bit words, buffers them in a small
// first-word-fall-through FIFO and tracks frame length and completed frames.
module ndp_result_packer #(
  parameter int WIDTH       = 16,
  parameter int FRAME_BEATS = 128,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_BITS    = 16
) (
  input  logic                axi_aclk,
  input  logic                axi_aresetn,
  input  logic                relu_en,
  input  logic                clear_status,
  input  logic [31:0]         s_axis_tdata,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [63:0]         m_axis_tdata,
  output logic [7:0]          m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                frame_err,
  output logic [CNT_BITS-1:0] frame_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    ST_EMPTY,
    ST_HALF
  } state_e;

  typedef struct packed {
    logic [7:0]  keep;
    logic        last;
    logic [63:0] data;
  } fifo_word_t;

  // Negative lanes (sign bit set) are forced to zero when ReLU is enabled.
  // Testing the sign bit alone also zeroes -0.0 and negative NaN encodings.
  function automatic logic [WIDTH-1:0] relu_lane(input logic signed [WIDTH-1:0] lane,
                                                 input logic                     en);
    relu_lane = (en && (lane < 0)) ? '0 : lane;
  endfunction

  logic                 ready_q;
  logic [CW-1:0]        count_q;
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  fifo_word_t           mem_q [FIFO_DEPTH];
  state_e               state_q;
  logic [31:0]          low_q;
  logic [15:0]          beat_idx_q;
  logic                 frame_err_q;
  logic [CNT_BITS-1:0]  frame_cnt_q;

  logic                 accept;
  logic                 pop;
  logic                 push;
  fifo_word_t           push_word;
  fifo_word_t           rd_word;
  logic [WIDTH-1:0]     lane0;
  logic [WIDTH-1:0]     lane1;
  logic [31:0]          beat;
  logic                 idx_at_last;
  logic                 err_evt;

  // Input handshake: ready only out of reset and while the FIFO has a free slot.
  // A pop in the same cycle does not open a slot for a push into a full FIFO.
  assign s_axis_tready = ready_q && (count_q != CW'(FIFO_DEPTH));
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign lane0 = relu_lane(s_axis_tdata[WIDTH-1:0], relu_en);
  assign lane1 = relu_lane(s_axis_tdata[2*WIDTH-1:WIDTH], relu_en);
  assign beat  = {lane1, lane0};

  // Output side: FWFT head of the FIFO, forced to zero while empty so no
  // uninitialised storage is ever visible on the bus.
  assign rd_word       = mem_q[rd_ptr_q];
  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? rd_word.data : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? rd_word.keep : '0;
  assign m_axis_tlast  = m_axis_tvalid ? rd_word.last : 1'b0;
  assign pop           = m_axis_tvalid && m_axis_tready;

  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

  // Input ready comes up on the first clock after reset is released.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  // Packer state: EMPTY waits for a first beat, HALF holds it until its partner.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q <= ST_EMPTY;
    end else if (accept) begin
      if (state_q == ST_EMPTY && !s_axis_tlast) begin
        state_q <= ST_HALF;
      end else begin
        state_q <= ST_EMPTY;
      end
    end
  end

  // Low half of a pending word; pure data, so it carries no reset.
  always_ff @(posedge axi_aclk) begin
    if (accept && state_q == ST_EMPTY) begin
      low_q <= beat;
    end
  end

  // Word assembly: a pair completes a full word, a lone last beat is flushed
  // as a half word with only the low four bytes enabled.
  always_comb begin
    push      = 1'b0;
    push_word = '0;
    if (accept) begin
      if (state_q == ST_HALF) begin
        push           = 1'b1;
        push_word.data = {beat, low_q};
        push_word.keep = 8'hFF;
        push_word.last = s_axis_tlast;
      end else if (s_axis_tlast) begin
        push           = 1'b1;
        push_word.data = {32'h0000_0000, beat};
        push_word.keep = 8'h0F;
        push_word.last = 1'b1;
      end
    end
  end

  // FIFO storage write; data only, so it carries no reset.
  always_ff @(posedge axi_aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // An error is a mismatch between tlast and the final-beat position:
  // tlast before the final index, or the final index without tlast.
  assign idx_at_last = (beat_idx_q == 16'(FRAME_BEATS - 1));
  assign err_evt     = accept && (s_axis_tlast != idx_at_last);

  // Beat index within the current frame; keeps counting (and wrapping) past
  // the expected length until tlast finally shows up.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      beat_idx_q <= '0;
    end else if (accept) begin
      if (s_axis_tlast) begin
        beat_idx_q <= '0;
      end else begin
        beat_idx_q <= beat_idx_q + 16'd1;
      end
    end
  end

  // Status: sticky error and drained-frame count; clear takes priority over
  // any event in the same cycle.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else if (clear_status) begin
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      if (err_evt) begin
        frame_err_q <= 1'b1;
      end
      if (pop && m_axis_tlast) begin
        frame_cnt_q <= frame_cnt_q + CNT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_ndp_result_packer.sv
// Testbench for ndp_result_packer: fixed vectors, directed multi-cycle
// sequences and randomized traffic checked against a frame-level model.
module tb_ndp_result_packer;

  localparam int WIDTH = 16;
  localparam int FB    = 128;
  localparam int FD    = 4;
  localparam int CB    = 16;

  logic          clk = 1'b0;
  logic          axi_aresetn;
  logic          relu_en = 1'b0;
  logic          clear_status = 1'b0;
  logic [31:0]   s_axis_tdata = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [63:0]   m_axis_tdata;
  logic [7:0]    m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          frame_err;
  logic [CB-1:0] frame_cnt;

  always #5 clk = ~clk;

  ndp_result_packer #(
    .WIDTH(WIDTH), .FRAME_BEATS(FB), .FIFO_DEPTH(FD), .CNT_BITS(CB)
  ) dut (
    .axi_aclk(clk), .axi_aresetn(axi_aresetn), .relu_en(relu_en),
    .clear_status(clear_status), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } word_t;

  typedef struct {
    logic [31:0] b0;
    logic [31:0] b1;
    logic        relu;
    logic [63:0] exp;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  word_t       act_q[$];
  word_t       exp_q[$];
  logic [31:0] mb_q[$];
  logic        ml_q[$];
  bit          rand_rdy = 0;
  word_t       mw;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Every handshaken output word is captured mid-cycle.
  always @(negedge clk) begin
    if (axi_aresetn === 1'b1 && m_axis_tvalid && m_axis_tready) begin
      mw.data = m_axis_tdata;
      mw.keep = m_axis_tkeep;
      mw.last = m_axis_tlast;
      act_q.push_back(mw);
    end
  end

  // Random downstream backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
  end

  function automatic logic [15:0] relu_ref(input logic [15:0] v, input logic en);
    if (en && $signed(v) < 0) return 16'h0000;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    @(negedge clk);
    while (!s_axis_tready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!s_axis_tready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: tready=%0b after %0d cycles, required 1", s_axis_tready, n);
    end else begin
      mb_q.push_back({relu_ref(d[31:16], relu_en), relu_ref(d[15:0], relu_en)});
      ml_q.push_back(l);
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    s_axis_tvalid = 1'b0;
    clear_status  = 1'b0;
    axi_aresetn   = 1'b0;
    repeat (cycles) step();
    axi_aresetn = 1'b1;
    act_q.delete();
    mb_q.delete();
    ml_q.delete();
    step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_rdy = 0;
    m_axis_tready = 1'b1;
    while (m_axis_tvalid && n < 200) begin
      step();
      n++;
    end
    if (m_axis_tvalid) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: tvalid=%0b, required 0", m_axis_tvalid);
    end
    step();
  endtask

  // Frame-level reference: split accepted beats into frames at tlast, chunk
  // each frame into pairs, flush an odd trailing beat as a half word.
  task automatic build_expected(output int frames, output bit err);
    int start;
    frames = 0;
    err    = 0;
    start  = 0;
    exp_q.delete();
    for (int i = 0; i < mb_q.size(); i++) begin
      if (ml_q[i] || i == mb_q.size() - 1) begin
        int n;
        bit term;
        n    = i - start + 1;
        term = ml_q[i];
        if (term) begin
          frames++;
          if (n != FB) err = 1;
        end else if (n >= FB) begin
          err = 1;
        end
        for (int j = 0; j < n; j += 2) begin
          word_t w;
          if (j + 1 < n) begin
            w.data = {mb_q[start+j+1], mb_q[start+j]};
            w.keep = 8'hFF;
            w.last = term && (j + 1 == n - 1);
            exp_q.push_back(w);
          end else if (term) begin
            w.data = {32'h0, mb_q[start+j]};
            w.keep = 8'h0F;
            w.last = 1'b1;
            exp_q.push_back(w);
          end
        end
        start = i + 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    int frames;
    bit err;
    build_expected(frames, err);
    check($sformatf("%s_nwords", tag), 64'(act_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), act_q[i].data, exp_q[i].data);
      check($sformatf("%s_ctl%0d", tag, i), {55'b0, act_q[i].keep, act_q[i].last},
            {55'b0, exp_q[i].keep, exp_q[i].last});
    end
    check($sformatf("%s_err", tag), 64'(frame_err), 64'(err));
    check($sformatf("%s_cnt", tag), 64'(frame_cnt), 64'(frames % (1 << CB)));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    vt[0] = '{32'h8000_3C00, 32'hFC00_BC00, 1'b1, 64'h0000_0000_0000_3C00};
    vt[1] = '{32'h8000_3C00, 32'hFC00_BC00, 1'b0, 64'hFC00_BC00_8000_3C00};
    vt[2] = '{32'h7FFF_0001, 32'hFFFF_8001, 1'b1, 64'h0000_0000_7FFF_0001};
    vt[3] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 64'h0000_0000_1234_5678};
    vt[4] = '{32'h0000_8000, 32'h7FFF_7FFF, 1'b1, 64'h7FFF_7FFF_0000_0000};

    // Reset values
    axi_aresetn = 1'b1;
    #2;
    axi_aresetn = 1'b0;
    step();
    step();
    check("rst_s_tready", 64'(s_axis_tready), 64'(0));
    check("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst_m_tlast", 64'(m_axis_tlast), 64'(0));
    check("rst_m_tdata", m_axis_tdata, 64'(0));
    check("rst_m_tkeep", 64'(m_axis_tkeep), 64'(0));
    check("rst_frame_err", 64'(frame_err), 64'(0));
    check("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    axi_aresetn = 1'b1;
    check("rst_ready_before_clk", 64'(s_axis_tready), 64'(0));
    step();
    check("rst_ready_after_clk", 64'(s_axis_tready), 64'(1));

    // Table-driven two-beat frames, ReLU on and off
    for (int v = 0; v < 5; v++) begin
      do_reset(1);
      relu_en = vt[v].relu;
      send_beat(vt[v].b0, 1'b0);
      send_beat(vt[v].b1, 1'b1);
      drain();
      check($sformatf("vec%0d_nwords", v), 64'(act_q.size()), 64'(1));
      if (act_q.size() >= 1) begin
        check($sformatf("vec%0d_data", v), act_q[0].data, vt[v].exp);
        check($sformatf("vec%0d_keep", v), 64'(act_q[0].keep), 64'(8'hFF));
        check($sformatf("vec%0d_last", v), 64'(act_q[0].last), 64'(1));
      end
      check($sformatf("vec%0d_err", v), 64'(frame_err), 64'(1));
      check($sformatf("vec%0d_cnt", v), 64'(frame_cnt), 64'(1));
    end
    relu_en = 1'b0;

    // Full 128-beat frame, lanes carry the beat index
    do_reset(1);
    for (int i = 0; i < FB; i++) send_beat({16'(i), 16'(i)}, i == FB - 1);
    drain();
    check("full_nwords", 64'(act_q.size()), 64'(64));
    for (int k = 0; k < act_q.size() && k < 64; k++) begin
      check($sformatf("full_data%0d", k), act_q[k].data,
            {16'(2*k+1), 16'(2*k+1), 16'(2*k), 16'(2*k)});
      check($sformatf("full_ctl%0d", k), {55'b0, act_q[k].keep, act_q[k].last},
            {55'b0, 8'hFF, k == 63});
    end
    check("full_err", 64'(frame_err), 64'(0));
    check("full_cnt", 64'(frame_cnt), 64'(1));

    // Odd, early tlast
    do_reset(1);
    send_beat(32'h1111_2222, 1'b0);
    send_beat(32'h3333_4444, 1'b0);
    send_beat(32'h5555_6666, 1'b1);
    drain();
    check("odd_nwords", 64'(act_q.size()), 64'(2));
    if (act_q.size() >= 2) begin
      check("odd_w0", act_q[0].data, 64'h3333_4444_1111_2222);
      check("odd_w0_ctl", {55'b0, act_q[0].keep, act_q[0].last}, {55'b0, 8'hFF, 1'b0});
      check("odd_w1", act_q[1].data, 64'h0000_0000_5555_6666);
      check("odd_w1_ctl", {55'b0, act_q[1].keep, act_q[1].last}, {55'b0, 8'h0F, 1'b1});
    end
    check("odd_err", 64'(frame_err), 64'(1));
    check("odd_cnt", 64'(frame_cnt), 64'(1));

    // Backpressure: FIFO fills after 8 beats, output held stable
    do_reset(1);
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 8; i++) send_beat(32'hA000_0000 + 32'(i), 1'b0);
    check("bp_ready_low", 64'(s_axis_tready), 64'(0));
    fork
      begin
        send_beat(32'hA000_0009, 1'b0);
        send_beat(32'hA000_000A, 1'b1);
      end
      begin
        for (int c = 0; c < 3; c++) begin
          step();
          check($sformatf("bp_hold%0d", c), m_axis_tdata, 64'hA000_0002_A000_0001);
          check($sformatf("bp_hold_vld%0d", c), 64'(m_axis_tvalid), 64'(1));
        end
        check("bp_ninth_blocked", 64'(mb_q.size()), 64'(8));
        m_axis_tready = 1'b1;
      end
    join
    drain();
    compare_all("bp");

    // Missing tlast, then clear
    do_reset(1);
    for (int i = 1; i <= 130; i++) begin
      send_beat(32'(i) * 32'h0001_0001, i == 130);
      if (i == 127) check("miss_err_at127", 64'(frame_err), 64'(0));
      if (i == 128) check("miss_err_at128", 64'(frame_err), 64'(1));
    end
    drain();
    compare_all("miss");
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    check("clr_err", 64'(frame_err), 64'(0));
    check("clr_cnt", 64'(frame_cnt), 64'(0));

    // Reset mid-frame with words still queued
    do_reset(1);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(32'hDEAD_0000 + 32'(i), 1'b0);
    do_reset(1);
    m_axis_tready = 1'b1;
    check("mid_rst_empty", 64'(m_axis_tvalid), 64'(0));
    for (int i = 0; i < FB; i++) send_beat($urandom, i == FB - 1);
    drain();
    check("mid_nwords64", 64'(act_q.size()), 64'(64));
    compare_all("mid");

    // Randomized frames, ReLU and backpressure
    do_reset(1);
    rand_rdy = 1;
    for (int f = 0; f < 20; f++) begin
      int len;
      case ($urandom_range(0, 5))
        4:       len = FB;
        5:       len = $urandom_range(FB - 1, FB + 1);
        default: len = $urandom_range(1, 7);
      endcase
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 2)) step();
        relu_en = 1'($urandom_range(0, 1));
        send_beat($urandom, b == len - 1);
      end
    end
    drain();
    compare_all("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
